// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/forward controller for the 5-stage pipeline
module pipe_hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int RA_W    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RA_W-1:0] D_rs1,
    input  logic [RA_W-1:0] D_rs2,
    input  logic [RA_W-1:0] E_rs1,
    input  logic [RA_W-1:0] E_rs2,
    input  logic [RA_W-1:0] E_rd,
    input  logic            E_reg_we,
    input  logic            E_is_load,
    input  logic            E_is_muldiv,
    input  logic            E_branch_taken,
    input  logic [RA_W-1:0] M_rd,
    input  logic            M_reg_we,
    input  logic [RA_W-1:0] W_rd,
    input  logic            W_reg_we,
    input  logic            dmem_req,
    input  logic            dmem_ready,
    output logic            F_stall,
    output logic            D_stall,
    output logic            E_stall,
    output logic            M_stall,
    output logic            D_flush,
    output logic            E_flush,
    output logic            M_flush,
    output logic            W_flush,
    output logic [1:0]      fwd_rs1_sel,
    output logic [1:0]      fwd_rs2_sel,
    output logic            muldiv_start,
    output logic            muldiv_busy,
    output logic [31:0]     stall_cycles
);

    // The start cycle and the release cycle are not counted in BUSY, hence -2.
    localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 2);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    logic mem_stall;
    logic lu_hit;
    logic md_start;
    logic md_stall;

    // M result is younger than W writeback, so it wins; x0 is hardwired zero.
    function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs);
        if (M_reg_we && (M_rd != '0) && (M_rd == rs))
            return 2'b01;
        else if (W_reg_we && (W_rd != '0) && (W_rd == rs))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign mem_stall = dmem_req & ~dmem_ready;
    assign lu_hit    = E_is_load & E_reg_we & (E_rd != '0) &
                       ((E_rd == D_rs1) | (E_rd == D_rs2));
    assign md_start  = (state_q == IDLE) & E_is_muldiv & ~mem_stall;
    assign md_stall  = md_start | ((state_q == BUSY) & (cnt_q != 4'd0));

    // Mul/div sequencer state and occupancy counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: the counter runs through memory waits, but release waits for memory.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (md_start) begin
                    state_d = BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0)
                    cnt_d = cnt_q - 4'd1;
                else if (!mem_stall)
                    state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Prioritised hold/bubble enables and forwarding selects, all forced low in reset.
    always_comb begin
        F_stall      = 1'b0;
        D_stall      = 1'b0;
        E_stall      = 1'b0;
        M_stall      = 1'b0;
        D_flush      = 1'b0;
        E_flush      = 1'b0;
        M_flush      = 1'b0;
        W_flush      = 1'b0;
        fwd_rs1_sel  = 2'b00;
        fwd_rs2_sel  = 2'b00;
        muldiv_start = 1'b0;
        muldiv_busy  = 1'b0;
        if (!rst) begin
            fwd_rs1_sel  = fwd_sel(E_rs1);
            fwd_rs2_sel  = fwd_sel(E_rs2);
            muldiv_start = md_start;
            muldiv_busy  = (state_q == BUSY);
            if (mem_stall) begin
                F_stall = 1'b1;
                D_stall = 1'b1;
                E_stall = 1'b1;
                M_stall = 1'b1;
                W_flush = 1'b1;
            end else if (md_stall) begin
                F_stall = 1'b1;
                D_stall = 1'b1;
                E_stall = 1'b1;
                M_flush = 1'b1;
            end else if (E_branch_taken) begin
                D_flush = 1'b1;
                E_flush = 1'b1;
            end else if (lu_hit) begin
                F_stall = 1'b1;
                D_stall = 1'b1;
                E_flush = 1'b1;
            end
        end
    end

    // Front-end stall counter for performance measurement; wraps naturally.
    always_comb begin
        stall_cycles_d = stall_cycles_q + (F_stall ? 32'd1 : 32'd0);
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cycles_q <= 32'd0;
        else
            stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam int MUL_LAT = 4;
    localparam int RA_W    = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [RA_W-1:0] D_rs1, D_rs2, E_rs1, E_rs2, E_rd, M_rd, W_rd;
    logic            E_reg_we, E_is_load, E_is_muldiv, E_branch_taken;
    logic            M_reg_we, W_reg_we, dmem_req, dmem_ready;
    logic            F_stall, D_stall, E_stall, M_stall;
    logic            D_flush, E_flush, M_flush, W_flush;
    logic [1:0]      fwd_rs1_sel, fwd_rs2_sel;
    logic            muldiv_start, muldiv_busy;
    logic [31:0]     stall_cycles;

    pipe_hazard_ctrl #(.MUL_LAT(MUL_LAT), .RA_W(RA_W)) dut (
        .clk(clk), .rst(rst),
        .D_rs1(D_rs1), .D_rs2(D_rs2), .E_rs1(E_rs1), .E_rs2(E_rs2), .E_rd(E_rd),
        .E_reg_we(E_reg_we), .E_is_load(E_is_load), .E_is_muldiv(E_is_muldiv),
        .E_branch_taken(E_branch_taken), .M_rd(M_rd), .M_reg_we(M_reg_we),
        .W_rd(W_rd), .W_reg_we(W_reg_we), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .F_stall(F_stall), .D_stall(D_stall), .E_stall(E_stall), .M_stall(M_stall),
        .D_flush(D_flush), .E_flush(E_flush), .M_flush(M_flush), .W_flush(W_flush),
        .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
        .muldiv_start(muldiv_start), .muldiv_busy(muldiv_busy),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] d_rs1, d_rs2, e_rs1, e_rs2, e_rd;
        logic       e_we, e_load, e_md, e_br;
        logic [4:0] m_rd;
        logic       m_we;
        logic [4:0] w_rd;
        logic       w_we, req, rdy;
    } stim_t;

    typedef struct packed {
        logic [3:0]  stl;   // F D E M
        logic [3:0]  fl;    // D E M W
        logic [1:0]  f1, f2;
        logic        start, busy;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   errors = 0;

    // Reference state: cycles elapsed since launch (0 = no mul/div in flight).
    int          occ   = 0;
    logic [31:0] m_cnt = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input stim_t s, input logic [4:0] rs);
        if (rs == 0) return 2'b00;
        if (s.m_we && s.m_rd == rs) return 2'b01;
        if (s.w_we && s.w_rd == rs) return 2'b10;
        return 2'b00;
    endfunction

    task automatic apply(input stim_t s);
        exp_t e;
        logic mem, lu, md, start;
        @(posedge clk);
        #1;
        D_rs1 = s.d_rs1; D_rs2 = s.d_rs2; E_rs1 = s.e_rs1; E_rs2 = s.e_rs2; E_rd = s.e_rd;
        E_reg_we = s.e_we; E_is_load = s.e_load; E_is_muldiv = s.e_md; E_branch_taken = s.e_br;
        M_rd = s.m_rd; M_reg_we = s.m_we; W_rd = s.w_rd; W_reg_we = s.w_we;
        dmem_req = s.req; dmem_ready = s.rdy;

        mem   = s.req && !s.rdy;
        lu    = s.e_load && s.e_we && s.e_rd != 0 && (s.e_rd == s.d_rs1 || s.e_rd == s.d_rs2);
        start = (occ == 0) && s.e_md && !mem;
        // E is held for MUL_LAT-1 cycles: the launch cycle plus occupancy cycles before the last.
        md    = start || (occ != 0 && occ < MUL_LAT - 1);

        e       = '0;
        e.f1    = ref_fwd(s, s.e_rs1);
        e.f2    = ref_fwd(s, s.e_rs2);
        e.start = start;
        e.busy  = (occ != 0);
        e.cnt   = m_cnt;
        if (mem)          begin e.stl = 4'b1111; e.fl = 4'b0001; end
        else if (md)      begin e.stl = 4'b1110; e.fl = 4'b0010; end
        else if (s.e_br)  begin e.stl = 4'b0000; e.fl = 4'b1100; end
        else if (lu)      begin e.stl = 4'b1100; e.fl = 4'b0100; end
        exp_q.push_back(e);

        if (e.stl[3]) m_cnt = m_cnt + 1;
        if (start)                  occ = 1;
        else if (occ != 0) begin
            if (occ < MUL_LAT - 1)  occ = occ + 1;
            else if (!mem)          occ = 0;
        end
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("stalls_FDEM",   {28'd0, F_stall, D_stall, E_stall, M_stall}, {28'd0, e.stl});
                check("flushes_DEMW",  {28'd0, D_flush, E_flush, M_flush, W_flush}, {28'd0, e.fl});
                check("fwd_rs1_sel",   {30'd0, fwd_rs1_sel}, {30'd0, e.f1});
                check("fwd_rs2_sel",   {30'd0, fwd_rs2_sel}, {30'd0, e.f2});
                check("muldiv_start",  {31'd0, muldiv_start}, {31'd0, e.start});
                check("muldiv_busy",   {31'd0, muldiv_busy}, {31'd0, e.busy});
                check("stall_cycles",  stall_cycles, e.cnt);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, {16'd0, F_stall, D_stall, E_stall, M_stall, D_flush, E_flush,
              M_flush, W_flush, fwd_rs1_sel, fwd_rs2_sel, muldiv_start, muldiv_busy, 2'b00}, 32'd0);
        check({tag, "_cnt"}, stall_cycles, 32'd0);
    endtask

    task automatic set_zero_inputs();
        {D_rs1, D_rs2, E_rs1, E_rs2, E_rd, M_rd, W_rd} = '0;
        {E_reg_we, E_is_load, E_is_muldiv, E_branch_taken} = '0;
        {M_reg_we, W_reg_we, dmem_req, dmem_ready} = '0;
    endtask

    initial begin
        stim_t s;
        set_zero_inputs();
        #2;
        // Reset with hazards on the inputs must still hold every output low.
        dmem_req = 1'b1; E_is_muldiv = 1'b1; M_reg_we = 1'b1; M_rd = 5'd3; E_rs1 = 5'd3;
        #1 check_all_zero("reset");
        set_zero_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Load-use: lw x5 in E, D reads x5 on rs2, then the bubble reaches E.
        s = '0; s.e_rd = 5; s.e_load = 1; s.e_we = 1; s.d_rs2 = 5; apply(s);
        s = '0; s.d_rs2 = 5; apply(s);

        // Forwarding: M beats W, then W alone, then x0 never forwarded.
        s = '0; s.m_rd = 3; s.w_rd = 3; s.m_we = 1; s.w_we = 1; s.e_rs1 = 3; s.e_rs2 = 3; apply(s);
        s.m_we = 0; apply(s);
        s.e_rs1 = 0; apply(s);

        // Mul/div held in E for its full occupancy.
        s = '0; s.e_md = 1; repeat (MUL_LAT) apply(s);
        s = '0; apply(s);

        // Memory wait overlapping a load-use, then the bubble once memory completes.
        s = '0; s.req = 1; s.e_rd = 7; s.e_load = 1; s.e_we = 1; s.d_rs1 = 7; repeat (5) apply(s);
        s.rdy = 1; apply(s);
        s = '0; apply(s);

        // Branch outranks load-use.
        s = '0; s.e_br = 1; s.e_rd = 2; s.e_load = 1; s.e_we = 1; s.d_rs1 = 2; apply(s);

        // Mul/div release delayed by a memory wait at the last occupancy cycle.
        s = '0; s.e_md = 1; repeat (MUL_LAT - 1) apply(s);
        s.req = 1; repeat (2) apply(s);
        s.req = 0; apply(s);
        s = '0; apply(s);

        // Randomized traffic with a small register namespace to provoke hazards.
        for (int i = 0; i < 1500; i++) begin
            s.d_rs1  = 5'($urandom_range(0, 3));
            s.d_rs2  = 5'($urandom_range(0, 3));
            s.e_rs1  = 5'($urandom_range(0, 3));
            s.e_rs2  = 5'($urandom_range(0, 3));
            s.e_rd   = 5'($urandom_range(0, 3));
            s.m_rd   = 5'($urandom_range(0, 3));
            s.w_rd   = 5'($urandom_range(0, 3));
            s.e_we   = 1'($urandom);
            s.e_load = 1'($urandom);
            s.e_md   = ($urandom_range(0, 3) == 0);
            s.e_br   = ($urandom_range(0, 3) == 0);
            s.m_we   = 1'($urandom);
            s.w_we   = 1'($urandom);
            s.req    = ($urandom_range(0, 2) == 0);
            s.rdy    = 1'($urandom);
            apply(s);
        end
        s = '0; repeat (MUL_LAT + 1) apply(s);

        // Asynchronous reset one cycle after launch.
        s = '0; s.e_md = 1; apply(s); apply(s);
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check_all_zero("reset_busy");
        @(posedge clk);
        set_zero_inputs();
        @(negedge clk);
        rst = 1'b0;
        occ = 0; m_cnt = 32'd0;
        #1;
        check("post_reset_busy", {31'd0, muldiv_busy}, 32'd0);
        check("post_reset_cnt", stall_cycles, 32'd0);
        s = '0; repeat (2) apply(s);
        s.e_md = 1; repeat (MUL_LAT) apply(s);
        s = '0; repeat (2) apply(s);

        @(negedge clk);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush/forward controller for the 5-stage pipeline (F/D/E/M/W).
- Generates per-stage hold and bubble enables for the pipeline registers.
- Generates operand-forwarding selects for the E stage.
- Sequences the multi-cycle mul/div unit with a counter FSM.
- Counts front-end stall cycles for performance measurement.

Parameters:
MUL_LAT, 4, cycles a mul/div instruction occupies E (legal range 2..16).
RA_W, 5, register-address width.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
D_rs1, D_rs2  in  RA_W  source registers of the instruction in D
E_rs1, E_rs2  in  RA_W  source registers of the instruction in E
E_rd  in  RA_W  destination register of the instruction in E
E_reg_we  in  1  E instruction writes the register file
E_is_load  in  1  E instruction is a load
E_is_muldiv  in  1  E instruction is mul/div
E_branch_taken  in  1  E resolved a taken branch or jump
M_rd  in  RA_W; M_reg_we  in  1  M-stage writeback info
W_rd  in  RA_W; W_reg_we  in  1  W-stage writeback info
dmem_req  in  1  M stage is accessing data memory
dmem_ready  in  1  data memory completes the access this cycle
F_stall, D_stall, E_stall, M_stall  out  1  hold the corresponding stage register
D_flush, E_flush, M_flush, W_flush  out  1  load a bubble into the corresponding register
fwd_rs1_sel, fwd_rs2_sel  out  2  00 = regfile, 01 = M ALU result, 10 = W writeback data
muldiv_start  out  1  one-cycle launch pulse to the mul/div unit
muldiv_busy  out  1  FSM is in BUSY
stall_cycles  out  32  count of cycles with F_stall = 1

Behaviour:
Reset:
- While rst = 1: every output is 0, state = IDLE, cnt = 0, stall_cycles = 0.

Combinational terms:
- mem_stall = dmem_req & ~dmem_ready.
- lu_hit = E_is_load & E_reg_we & (E_rd != 0) & ((E_rd == D_rs1) | (E_rd == D_rs2)).
- md_stall = (IDLE & E_is_muldiv & ~mem_stall) | (BUSY & cnt != 0).

Priority (highest first). Outputs not named in a rule are 0:
1. mem_stall: F/D/E/M_stall = 1, W_flush = 1. Branch and load-use handling suppressed.
2. md_stall: F/D/E_stall = 1, M_flush = 1. Branch and load-use handling suppressed.
3. E_branch_taken: D_flush = 1, E_flush = 1. Load-use suppressed because the D instruction is discarded.
4. lu_hit: F_stall = 1, D_stall = 1, E_flush = 1. Exactly one bubble is inserted.

Forwarding (per source operand; rs1 shown, rs2 identical):
- Select 01 if M_reg_we & M_rd != 0 & M_rd == E_rs1.
- Else select 10 if W_reg_we & W_rd != 0 & W_rd == E_rs1.
- Else select 00.
- M has priority over W. Register 0 is never forwarded.
- Selects are valid regardless of stalls.

Mul/div FSM (states IDLE, BUSY; 4-bit down-counter cnt):
- IDLE & E_is_muldiv & ~mem_stall: muldiv_start = 1 for this cycle only; cnt <= MUL_LAT-2; next state BUSY.
- IDLE & E_is_muldiv & mem_stall: no start pulse; remain IDLE. Start is deferred until mem_stall drops.
- BUSY & cnt != 0: cnt decrements every cycle, including cycles with mem_stall.
- BUSY & cnt == 0 & ~mem_stall: no md stall; next state IDLE. The E instruction advances this cycle.
- BUSY & cnt == 0 & mem_stall: remain in BUSY until mem_stall drops.
- Net timing: E occupancy = MUL_LAT cycles, with MUL_LAT-1 md stall cycles. No restart on the release cycle because the state is BUSY.
- E_branch_taken is ignored in any cycle where E_stall = 1.

Counter:
- stall_cycles increments by 1 on every clock with F_stall = 1.
- Wraps 0xFFFFFFFF to 0.

Reset mid-operation:
- Asynchronous reset aborts BUSY and MEMWAIT-equivalent conditions immediately.
- The mul/div unit result is discarded; muldiv_start is not reissued until a fresh E_is_muldiv after reset release.

Test Plan:
1. Load-use: E = lw x5 (E_rd = 5, E_is_load = 1, E_reg_we = 1), D_rs2 = 5 -> exactly 1 cycle with F_stall = D_stall = E_flush = 1; stall_cycles goes 0 -> 1.
2. Forwarding: M_rd = 3 and W_rd = 3 with both write enables = 1, E_rs1 = 3 -> fwd_rs1_sel = 01. Set M_reg_we = 0 -> 10. Set E_rs1 = 0 -> 00.
3. Mul/div, MUL_LAT = 4: E_is_muldiv held high -> muldiv_start high for 1 cycle only; E_stall high for 3 cycles then low; muldiv_busy high for 3 cycles; M_flush high for 3 cycles.
4. Memory wait: dmem_req = 1, dmem_ready = 0 for 5 cycles, with a simultaneous lu_hit -> F/D/E/M_stall and W_flush high for 5 cycles, E_flush stays 0. Load-use bubble follows once dmem_ready = 1.
5. Branch vs load-use: E_branch_taken = 1 and lu_hit = 1 in the same cycle -> D_flush = E_flush = 1, F_stall = 0.
6. Reset mid-BUSY: assert rst asynchronously 1 cycle after muldiv_start -> all outputs 0 immediately; after release with E_is_muldiv = 0, state is IDLE and stall_cycles = 0.
